// File: rtl/mux_bus_arbiter_if.sv
// Bundle of request/data/handshake signals between four producers, the arbiter and the consumer.
// The arbiter uses the slave view; the producers and consumer together use the master view.
interface mux_bus_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [3:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] data3;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       select;
    logic [3:0]       grant;
    logic [3:0]       ack;
    logic             busy;

    modport master (
        output req, data0, data1, data2, data3, out_ready,
        input  out_valid, out_data, select, grant, ack, busy
    );

    modport slave (
        input  req, data0, data1, data2, data3, out_ready,
        output out_valid, out_data, select, grant, ack, busy
    );
endinterface

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit bus among four requesters, with bursts of up to
// BURST_MAX beats per grant and a valid/ready handshake toward the consumer.
module mux_bus_arbiter #(
    parameter int WIDTH     = 16,
    parameter int BURST_MAX = 4
) (
    input logic             clk,
    input logic             reset,
    mux_bus_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(BURST_MAX) + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state;
    logic [3:0]       grant_r;
    logic [1:0]       select_r;
    logic [1:0]       last;
    logic [CNT_W-1:0] beat_cnt;

    logic [1:0]       pick;
    logic [1:0]       cand;
    logic             found;
    logic             valid;
    logic             beat;
    logic             last_beat;
    logic [WIDTH-1:0] data_mux;

    // Rotating priority: the requester just after the previous owner is looked at first.
    always_comb begin
        pick  = last;
        cand  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && bus.req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (select_r)
            2'd0:    data_mux = bus.data0;
            2'd1:    data_mux = bus.data1;
            2'd2:    data_mux = bus.data2;
            default: data_mux = bus.data3;
        endcase
    end

    // Reset suppresses the handshake in its own cycle so an in-flight beat is never acked.
    assign valid     = (state == GRANT) && bus.req[select_r] && !reset;
    assign beat      = valid && bus.out_ready;
    assign last_beat = (beat_cnt == CNT_W'(BURST_MAX - 1));

    assign bus.out_valid = valid;
    assign bus.out_data  = data_mux;
    assign bus.select    = select_r;
    assign bus.grant     = grant_r;
    assign bus.ack       = beat ? (4'b0001 << select_r) : 4'b0000;
    assign bus.busy      = (state == GRANT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant_r  <= 4'b0000;
            select_r <= 2'd0;
            last     <= 2'd3;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        grant_r  <= 4'b0001 << pick;
                        select_r <= pick;
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    // Withdrawal or a full burst both hand the bus back; select is kept while idle.
                    if (!bus.req[select_r] || (beat && last_beat)) begin
                        state    <= IDLE;
                        last     <= select_r;
                        grant_r  <= 4'b0000;
                        beat_cnt <= '0;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Bench for mux_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level round-robin model.
module tb_mux_bus_arbiter;
    localparam int WIDTH     = 16;
    localparam int BURST_MAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux_bus_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_bus_arbiter #(.WIDTH(WIDTH), .BURST_MAX(BURST_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    // Model: owner index (-1 when nobody holds the bus), previous owner, beats done in this grant.
    int         m_owner = -1;
    int         m_last  = 3;
    int         m_beats = 0;
    logic [1:0] m_sel   = 2'd0;

    function automatic int rr_pick(int prev, logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(prev + k) % 4]) return (prev + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_owner <= -1;
            m_last  <= 3;
            m_beats <= 0;
            m_sel   <= 2'd0;
        end else if (m_owner < 0) begin
            if (bus.req != 4'b0000) begin
                m_owner <= rr_pick(m_last, bus.req);
                m_sel   <= 2'(rr_pick(m_last, bus.req));
                m_beats <= 0;
            end
        end else if (!bus.req[m_owner]) begin
            m_last  <= m_owner;
            m_owner <= -1;
            m_beats <= 0;
        end else if (bus.out_ready) begin
            if (m_beats + 1 == BURST_MAX) begin
                m_last  <= m_owner;
                m_owner <= -1;
                m_beats <= 0;
            end else begin
                m_beats <= m_beats + 1;
            end
        end
    end

    function automatic logic [3:0] exp_grant();
        return (m_owner < 0) ? 4'b0000 : 4'(32'd1 << m_owner);
    endfunction

    function automatic logic exp_valid();
        return !reset && (m_owner >= 0) && bus.req[m_owner];
    endfunction

    function automatic logic [3:0] exp_ack();
        return (exp_valid() && bus.out_ready) ? exp_grant() : 4'b0000;
    endfunction

    function automatic logic [WIDTH-1:0] exp_data();
        case (m_sel)
            2'd0:    return bus.data0;
            2'd1:    return bus.data1;
            2'd2:    return bus.data2;
            default: return bus.data3;
        endcase
    endfunction

    task automatic set_data(int i, logic [WIDTH-1:0] v);
        case (i)
            0:       bus.data0 = v;
            1:       bus.data1 = v;
            2:       bus.data2 = v;
            default: bus.data3 = v;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.data0 = 16'h1234;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.req = 4'b0000;
            #1;
            checks++; if (bus.grant !== 4'b0000) $display("FAIL reset_grant c%0d: got %b want 0000", c, bus.grant); else passes++;
            checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid c%0d: got %b want 0", c, bus.out_valid); else passes++;
            checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy c%0d: got %b want 0", c, bus.busy); else passes++;
            checks++; if (bus.select !== 2'd0) $display("FAIL reset_select c%0d: got %0d want 0", c, bus.select); else passes++;
            checks++; if (bus.ack !== 4'b0000) $display("FAIL reset_ack c%0d: got %b want 0000", c, bus.ack); else passes++;
            checks++; if (bus.out_data !== 16'h1234) $display("FAIL reset_data c%0d: got %h want 1234", c, bus.out_data); else passes++;
        end
    endtask

    // Every requester busy: each grant is one idle cycle followed by BURST_MAX beats.
    task automatic test_round_robin();
        logic [3:0] g;
        do_reset();
        for (int c = 0; c < 5 * (BURST_MAX + 1); c++) begin
            @(negedge clk);
            bus.req       = 4'b1111;
            bus.out_ready = 1'b1;
            #1;
            g = (c % (BURST_MAX + 1) == 0) ? 4'b0000 : 4'(32'd1 << ((c / (BURST_MAX + 1)) % 4));
            checks++; if (bus.grant !== g) $display("FAIL rr_grant c%0d: got %b want %b", c, bus.grant, g); else passes++;
            checks++; if (bus.ack !== g) $display("FAIL rr_ack c%0d: got %b want %b", c, bus.ack, g); else passes++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.data2 = 16'hBEEF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.req       = 4'b0100;
            bus.out_ready = (c == 4);
            #1;
            if (c >= 1) begin
                checks++; if (bus.select !== 2'd2) $display("FAIL stall_select c%0d: got %0d want 2", c, bus.select); else passes++;
                checks++; if (bus.out_valid !== 1'b1) $display("FAIL stall_valid c%0d: got %b want 1", c, bus.out_valid); else passes++;
                checks++; if (bus.out_data !== 16'hBEEF) $display("FAIL stall_data c%0d: got %h want beef", c, bus.out_data); else passes++;
                checks++; if (bus.ack !== ((c == 4) ? 4'b0100 : 4'b0000)) $display("FAIL stall_ack c%0d: got %b want %b", c, bus.ack, (c == 4) ? 4'b0100 : 4'b0000); else passes++;
            end
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        @(negedge clk); bus.req = 4'b0010; bus.out_ready = 1'b1; #1;
        @(negedge clk); #1;
        checks++; if (bus.ack !== 4'b0010) $display("FAIL wd_first_ack: got %b want 0010", bus.ack); else passes++;
        @(negedge clk); bus.req = 4'b0000; #1;
        checks++; if (bus.ack !== 4'b0000) $display("FAIL wd_no_ack: got %b want 0000", bus.ack); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL wd_valid: got %b want 0", bus.out_valid); else passes++;
        @(negedge clk); bus.req = 4'b0011; #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL wd_idle_busy: got %b want 0", bus.busy); else passes++;
        checks++; if (bus.grant !== 4'b0000) $display("FAIL wd_idle_grant: got %b want 0000", bus.grant); else passes++;
        checks++; if (bus.select !== 2'd1) $display("FAIL wd_select_hold: got %0d want 1", bus.select); else passes++;
        @(negedge clk); #1;
        checks++; if (bus.grant !== 4'b0001) $display("FAIL wd_next_grant: got %b want 0001", bus.grant); else passes++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        @(negedge clk); bus.req = 4'b1000; bus.out_ready = 1'b1; #1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk); #1;
            checks++; if (bus.ack !== 4'b1000) $display("FAIL mid_ack c%0d: got %b want 1000", c, bus.ack); else passes++;
        end
        @(negedge clk); reset = 1'b1; #1;
        checks++; if (bus.ack !== 4'b0000) $display("FAIL mid_reset_ack: got %b want 0000", bus.ack); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", bus.out_valid); else passes++;
        @(negedge clk); reset = 1'b0; bus.req = 4'b1001; #1;
        checks++; if (bus.grant !== 4'b0000) $display("FAIL mid_after_grant: got %b want 0000", bus.grant); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL mid_after_busy: got %b want 0", bus.busy); else passes++;
        @(negedge clk); #1;
        checks++; if (bus.grant !== 4'b0001) $display("FAIL mid_regrant: got %b want 0001", bus.grant); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] g;
        do_reset();
        for (int c = 0; c < 3 * (BURST_MAX + 1); c++) begin
            @(negedge clk);
            bus.req       = 4'b0001;
            bus.out_ready = 1'b1;
            #1;
            g = (c % (BURST_MAX + 1) == 0) ? 4'b0000 : 4'b0001;
            checks++; if (bus.ack !== g) $display("FAIL b2b_ack c%0d: got %b want %b", c, bus.ack, g); else passes++;
            checks++; if (bus.busy !== (g != 4'b0000)) $display("FAIL b2b_busy c%0d: got %b want %b", c, bus.busy, g != 4'b0000); else passes++;
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] prev_ack;
        prev_ack = 4'b0000;
        do_reset();
        for (int i = 0; i < 4; i++) set_data(i, WIDTH'($urandom));
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 79) == 0);
            r = bus.req;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 4) == 0) r[i] = ~r[i];
            end
            bus.req = r;
            for (int i = 0; i < 4; i++) begin
                if (!r[i] || prev_ack[i]) set_data(i, WIDTH'($urandom));
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++; if (bus.grant !== exp_grant()) $display("FAIL rnd_grant c%0d: got %b want %b", c, bus.grant, exp_grant()); else passes++;
            checks++; if (bus.out_valid !== exp_valid()) $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.out_valid, exp_valid()); else passes++;
            checks++; if (bus.ack !== exp_ack()) $display("FAIL rnd_ack c%0d: got %b want %b", c, bus.ack, exp_ack()); else passes++;
            checks++; if (bus.select !== m_sel) $display("FAIL rnd_select c%0d: got %0d want %0d", c, bus.select, m_sel); else passes++;
            checks++; if (bus.busy !== (m_owner >= 0)) $display("FAIL rnd_busy c%0d: got %b want %b", c, bus.busy, m_owner >= 0); else passes++;
            checks++; if (bus.out_data !== exp_data()) $display("FAIL rnd_data c%0d: got %h want %h", c, bus.out_data, exp_data()); else passes++;
            prev_ack = bus.ack;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        bus.data0     = '0;
        bus.data1     = '0;
        bus.data2     = '0;
        bus.data3     = '0;
        test_reset();
        test_round_robin();
        test_stall();
        test_withdraw();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
